// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter
//   Two-port round-robin arbiter and sequencer in front of a single-ported
//   data memory. Accesses are serialised through IDLE -> ISSUE -> (WAIT) ->
//   RESP, and each one completes with a one-cycle Ack pulse.
//
// Ports:
//   Clock, Reset            clock (posedge state changes), async active-high reset
//   Req/We/Addr/WData[0|1]  requester access request, held until Ack
//   Ack[0|1], RData[0|1]    registered completion pulse and load data
//   MemAddress, MemWriteData, MemoryRead, MemoryWrite, MemReadData
//                           single-ported memory interface (one strobe at a time)
//   Busy                    high whenever the sequencer is not in IDLE
module data_memory_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Req0,
  input  logic                  We0,
  input  logic [ADDR_WIDTH-1:0] Addr0,
  input  logic [DATA_WIDTH-1:0] WData0,
  output logic                  Ack0,
  output logic [DATA_WIDTH-1:0] RData0,
  input  logic                  Req1,
  input  logic                  We1,
  input  logic [ADDR_WIDTH-1:0] Addr1,
  input  logic [DATA_WIDTH-1:0] WData1,
  output logic                  Ack1,
  output logic [DATA_WIDTH-1:0] RData1,
  output logic [ADDR_WIDTH-1:0] MemAddress,
  output logic [DATA_WIDTH-1:0] MemWriteData,
  output logic                  MemoryRead,
  output logic                  MemoryWrite,
  input  logic [DATA_WIDTH-1:0] MemReadData,
  output logic                  Busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  winner_q, winner_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  mem_rd_q, mem_rd_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  busy_q, busy_d;
  logic                  pick;
  logic                  pick_we;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    winner_d     = winner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mem_rd_d     = 1'b0;
    mem_wr_d     = 1'b0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    // On a tie the requester that did not win last time gets the grant.
    pick         = (Req0 && Req1) ? ~last_grant_q : Req1;
    pick_we      = pick ? We1 : We0;

    unique case (state_q)
      S_IDLE: begin
        if (Req0 || Req1) begin
          winner_d     = pick;
          last_grant_d = pick;
          we_d         = pick_we;
          addr_d       = pick ? Addr1 : Addr0;
          wdata_d      = pick ? WData1 : WData0;
          // Strobes are registered so they are valid for the whole ISSUE cycle.
          mem_rd_d     = ~pick_we;
          mem_wr_d     = pick_we;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_RESP;
          ack0_d  = ~winner_q;
          ack1_d  = winner_q;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Memory output has settled by the end of WAIT.
        if (winner_q) rdata1_d = MemReadData;
        else          rdata0_d = MemReadData;
        ack0_d  = ~winner_q;
        ack1_d  = winner_q;
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      winner_q     <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      winner_q     <= winner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      busy_q       <= busy_d;
    end
  end

  // Latched request copies drive the memory directly; they are held
  // outside ISSUE so the address stays stable through WAIT.
  assign MemAddress   = addr_q;
  assign MemWriteData = wdata_q;
  assign MemoryRead   = mem_rd_q;
  assign MemoryWrite  = mem_wr_q;
  assign Ack0         = ack0_q;
  assign Ack1         = ack1_q;
  assign RData0       = rdata0_q;
  assign RData1       = rdata1_q;
  assign Busy         = busy_q;

endmodule
